// File: rtl/bp_io_cmd_router_if.sv
// Command/response bundle between the core I/O port, the router and its two targets.
// Signal names keep the router-side direction suffixes so the slave modport reads naturally.
interface bp_io_cmd_router_if #(
    parameter int msg_width_p = 128
);
    logic [msg_width_p-1:0]   io_cmd_i;
    logic                     io_cmd_v_i;
    logic                     io_cmd_ready_o;
    logic [msg_width_p-1:0]   io_resp_o;
    logic                     io_resp_v_o;
    logic                     io_resp_yumi_i;
    logic [msg_width_p-1:0]   tgt_cmd_o;
    logic [1:0]               tgt_cmd_v_o;
    logic [1:0]               tgt_cmd_ready_i;
    logic [2*msg_width_p-1:0] tgt_resp_i;
    logic [1:0]               tgt_resp_v_i;
    logic [1:0]               tgt_resp_yumi_o;

    modport slave (
        input  io_cmd_i, io_cmd_v_i, io_resp_yumi_i,
        input  tgt_cmd_ready_i, tgt_resp_i, tgt_resp_v_i,
        output io_cmd_ready_o, io_resp_o, io_resp_v_o,
        output tgt_cmd_o, tgt_cmd_v_o, tgt_resp_yumi_o
    );

    modport master (
        output io_cmd_i, io_cmd_v_i, io_resp_yumi_i,
        output tgt_cmd_ready_i, tgt_resp_i, tgt_resp_v_i,
        input  io_cmd_ready_o, io_resp_o, io_resp_v_o,
        input  tgt_cmd_o, tgt_cmd_v_o, tgt_resp_yumi_o
    );
endinterface

// File: rtl/bp_io_cmd_router.sv
// Steers I/O commands to the host window (target 0) or the default port (target 1)
// and returns responses to the core strictly in command order.
module bp_io_cmd_router #(
    parameter int                     msg_width_p       = 128,
    parameter int                     paddr_width_p     = 40,
    parameter int                     addr_lsb_p        = 0,
    parameter logic [paddr_width_p-1:0] host_base_p     = 40'h00_0010_0000,
    parameter logic [paddr_width_p-1:0] host_size_p     = 40'h00_0010_0000,
    parameter int                     max_outstanding_p = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    bp_io_cmd_router_if.slave                  io,
    output logic [$clog2(max_outstanding_p):0] outstanding_o,
    output logic                               err_o
);
    localparam int ptr_w = $clog2(max_outstanding_p);
    localparam int cnt_w = ptr_w + 1;

    // Window compare is one bit wider so base+size cannot wrap to a small value.
    logic [paddr_width_p-1:0] addr;
    logic [paddr_width_p:0]   addr_ext;
    logic [paddr_width_p:0]   win_lo;
    logic [paddr_width_p:0]   win_hi;
    logic                     sel;

    assign addr     = io.io_cmd_i[addr_lsb_p +: paddr_width_p];
    assign addr_ext = {1'b0, addr};
    assign win_lo   = {1'b0, host_base_p};
    assign win_hi   = win_lo + {1'b0, host_size_p};
    assign sel      = ~((addr_ext >= win_lo) && (addr_ext < win_hi));

    logic             sel_fifo_mem [max_outstanding_p];
    logic [ptr_w-1:0] wr_ptr_reg;
    logic [ptr_w-1:0] rd_ptr_reg;
    logic [cnt_w-1:0] count_reg;
    logic             err_reg;
    logic             full;
    logic             empty;
    logic             head;
    logic             cmd_ready;
    logic             resp_v;
    logic             push;
    logic             pop;
    logic [1:0]       err_hit;

    assign full  = (count_reg == cnt_w'(max_outstanding_p));
    assign empty = (count_reg == '0);
    assign head  = sel_fifo_mem[rd_ptr_reg];

    // Handshake outputs are gated by reset so they drop the instant reset asserts.
    assign cmd_ready = reset_n_i & ~full & io.tgt_cmd_ready_i[sel];
    assign resp_v    = reset_n_i & ~empty & io.tgt_resp_v_i[head];
    assign push      = io.io_cmd_v_i & cmd_ready;
    assign pop       = io.io_resp_yumi_i & resp_v;

    assign io.tgt_cmd_o      = io.io_cmd_i;
    assign io.io_cmd_ready_o = cmd_ready;
    assign io.io_resp_v_o    = resp_v;
    assign io.io_resp_o      = head ? io.tgt_resp_i[msg_width_p +: msg_width_p]
                                    : io.tgt_resp_i[0 +: msg_width_p];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_tgt
            logic             push_hit;
            logic             pop_hit;
            logic [cnt_w-1:0] pend_reg;

            assign push_hit = push & (sel == 1'(gi));
            assign pop_hit  = pop & (head == 1'(gi));

            assign io.tgt_cmd_v_o[gi]     = reset_n_i & io.io_cmd_v_i & ~full & (sel == 1'(gi));
            assign io.tgt_resp_yumi_o[gi] = pop_hit;

            // Per-target pending count; a valid response with none pending is an error.
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    pend_reg <= '0;
                end else if (push_hit && !pop_hit) begin
                    pend_reg <= pend_reg + cnt_w'(1);
                end else if (pop_hit && !push_hit) begin
                    pend_reg <= pend_reg - cnt_w'(1);
                end
            end

            assign err_hit[gi] = io.tgt_resp_v_i[gi] & (pend_reg == '0);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (push) begin
            sel_fifo_mem[wr_ptr_reg] <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + cnt_w'(1);
                2'b01:   count_reg <= count_reg - cnt_w'(1);
                default: count_reg <= count_reg;
            endcase
            if (|err_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign outstanding_o = count_reg;
    assign err_o         = err_reg;

`ifndef SYNTHESIS
    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        io.io_resp_yumi_i |-> io.io_resp_v_o);
    a_cmd_v_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(&io.tgt_cmd_v_o));
`endif
endmodule

// File: tb/tb_bp_io_cmd_router.sv
// Self-checking bench: decode vector table, directed ordering/full/error/reset
// sequences, then random traffic against a queue-based reference model.
module tb_bp_io_cmd_router;
    localparam longint host_base = 64'h10_0000;
    localparam longint host_size = 64'h10_0000;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] outstanding;
    logic       err;
    int         n_cmp = 0;
    int         n_bad = 0;

    bp_io_cmd_router_if #(.msg_width_p(128)) bus();

    bp_io_cmd_router dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .io           (bus),
        .outstanding_o(outstanding),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] addr;
        logic [1:0]  rdy;
        logic [1:0]  exp_v;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.io_cmd_i        = '0;
        bus.io_cmd_v_i      = 1'b0;
        bus.io_resp_yumi_i  = 1'b0;
        bus.tgt_cmd_ready_i = 2'b11;
        bus.tgt_resp_i      = '0;
        bus.tgt_resp_v_i    = 2'b00;
    endtask

    function automatic logic [127:0] mk_cmd(input logic [39:0] a);
        return {$urandom, $urandom, 24'($urandom), a};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int ref_sel(input logic [39:0] a);
        longint x;
        x = longint'(a);
        return (x >= host_base && x < host_base + host_size) ? 0 : 1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] cmd;
        logic [127:0] d0;
        logic [127:0] d1;
        int           q[$];

        vecs[0] = '{40'h00_0010_0040, 2'b11, 2'b01, 1'b1};
        vecs[1] = '{40'h00_000F_FFFF, 2'b11, 2'b10, 1'b1};
        vecs[2] = '{40'h00_0010_0000, 2'b11, 2'b01, 1'b1};
        vecs[3] = '{40'h00_001F_FFFF, 2'b11, 2'b01, 1'b1};
        vecs[4] = '{40'h00_0020_0000, 2'b11, 2'b10, 1'b1};
        vecs[5] = '{40'h00_0010_0000, 2'b10, 2'b01, 1'b0};
        vecs[6] = '{40'h00_0020_0000, 2'b10, 2'b10, 1'b1};
        vecs[7] = '{40'h00_0000_0000, 2'b01, 2'b10, 1'b0};
        vecs[8] = '{40'hFF_FFFF_FFFF, 2'b11, 2'b10, 1'b1};
        vecs[9] = '{40'h00_0015_5555, 2'b01, 2'b01, 1'b1};

        // Reset state
        idle();
        bus.io_cmd_v_i   = 1'b1;
        bus.tgt_resp_v_i = 2'b11;
        #3;
        chk("rst_outstanding", 128'(outstanding), 0);
        chk("rst_err", 128'(err), 0);
        chk("rst_cmd_ready", 128'(bus.io_cmd_ready_o), 0);
        chk("rst_resp_v", 128'(bus.io_resp_v_o), 0);
        chk("rst_tgt_cmd_v", 128'(bus.tgt_cmd_v_o), 0);
        chk("rst_tgt_yumi", 128'(bus.tgt_resp_yumi_o), 0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Decode table, combinational only; valid drops before each edge
        for (int i = 0; i < 10; i++) begin
            tick();
            cmd = mk_cmd(vecs[i].addr);
            bus.io_cmd_i        = cmd;
            bus.tgt_cmd_ready_i = vecs[i].rdy;
            bus.io_cmd_v_i      = 1'b1;
            #1;
            chk($sformatf("vec%0d_tgt_cmd_v", i), 128'(bus.tgt_cmd_v_o), 128'(vecs[i].exp_v));
            chk($sformatf("vec%0d_cmd_ready", i), 128'(bus.io_cmd_ready_o), 128'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_tgt_cmd", i), bus.tgt_cmd_o, cmd);
            bus.io_cmd_v_i = 1'b0;
            $display("vec %0d addr=%h rdy=%b", i, vecs[i].addr, vecs[i].rdy);
        end
        tick();
        idle();
        chk("vec_no_push", 128'(outstanding), 0);

        // Single host access
        tick();
        bus.io_cmd_i   = mk_cmd(40'h00_0010_0040);
        bus.io_cmd_v_i = 1'b1;
        #1;
        chk("host_tgt_cmd_v", 128'(bus.tgt_cmd_v_o), 128'(2'b01));
        tick();
        bus.io_cmd_v_i = 1'b0;
        chk("host_outstanding1", 128'(outstanding), 1);
        chk("host_resp_v_idle", 128'(bus.io_resp_v_o), 0);
        tick();
        tick();
        d0 = rnd128();
        bus.tgt_resp_i[127:0] = d0;
        bus.tgt_resp_v_i      = 2'b01;
        #1;
        chk("host_resp_v", 128'(bus.io_resp_v_o), 1);
        chk("host_resp_data", bus.io_resp_o, d0);
        chk("host_yumi_hold", 128'(bus.tgt_resp_yumi_o), 0);
        bus.io_resp_yumi_i = 1'b1;
        #1;
        chk("host_yumi", 128'(bus.tgt_resp_yumi_o), 128'(2'b01));
        tick();
        idle();
        chk("host_outstanding0", 128'(outstanding), 0);
        $display("seq host access done");

        // Ordering: target 1 then target 0, target 0 answers first
        bus.io_cmd_i   = mk_cmd(40'h0);
        bus.io_cmd_v_i = 1'b1;
        tick();
        bus.io_cmd_i = mk_cmd(40'h00_0010_0000);
        tick();
        bus.io_cmd_v_i = 1'b0;
        chk("ord_outstanding2", 128'(outstanding), 2);
        d0 = rnd128();
        d1 = rnd128();
        bus.tgt_resp_i[127:0] = d0;
        bus.tgt_resp_v_i      = 2'b01;
        #1;
        chk("ord_wait_v0", 128'(bus.io_resp_v_o), 0);
        tick();
        chk("ord_wait_v1", 128'(bus.io_resp_v_o), 0);
        tick();
        bus.tgt_resp_i[255:128] = d1;
        bus.tgt_resp_v_i        = 2'b11;
        #1;
        chk("ord_t1_v", 128'(bus.io_resp_v_o), 1);
        chk("ord_t1_data", bus.io_resp_o, d1);
        bus.io_resp_yumi_i = 1'b1;
        #1;
        chk("ord_t1_yumi", 128'(bus.tgt_resp_yumi_o), 128'(2'b10));
        tick();
        bus.tgt_resp_v_i = 2'b01;
        #1;
        chk("ord_t0_v", 128'(bus.io_resp_v_o), 1);
        chk("ord_t0_data", bus.io_resp_o, d0);
        chk("ord_t0_yumi", 128'(bus.tgt_resp_yumi_o), 128'(2'b01));
        tick();
        idle();
        chk("ord_outstanding0", 128'(outstanding), 0);
        chk("ord_err", 128'(err), 0);
        $display("seq ordering done");

        // Full: four outstanding, no bypass on the pop cycle
        for (int i = 0; i < 4; i++) begin
            bus.io_cmd_i   = mk_cmd(40'h00_0030_0000 + 40'(i));
            bus.io_cmd_v_i = 1'b1;
            tick();
        end
        chk("full_outstanding4", 128'(outstanding), 4);
        chk("full_ready", 128'(bus.io_cmd_ready_o), 0);
        chk("full_tgt_cmd_v", 128'(bus.tgt_cmd_v_o), 0);
        d1 = rnd128();
        bus.tgt_resp_i[255:128] = d1;
        bus.tgt_resp_v_i        = 2'b10;
        bus.io_resp_yumi_i      = 1'b1;
        #1;
        chk("full_pop_v", 128'(bus.io_resp_v_o), 1);
        chk("full_pop_ready", 128'(bus.io_cmd_ready_o), 0);
        tick();
        bus.io_resp_yumi_i = 1'b0;
        chk("full_after_ready", 128'(bus.io_cmd_ready_o), 1);
        chk("full_after_outstanding", 128'(outstanding), 3);
        bus.io_cmd_v_i     = 1'b0;
        bus.io_resp_yumi_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        idle();
        chk("full_drain", 128'(outstanding), 0);
        $display("seq full done");

        // Error on an unexpected response, sticky
        bus.tgt_resp_v_i = 2'b01;
        #1;
        chk("err_same_cycle", 128'(err), 0);
        tick();
        bus.tgt_resp_v_i = 2'b00;
        chk("err_set", 128'(err), 1);
        tick();
        tick();
        chk("err_sticky", 128'(err), 1);

        // Asynchronous reset mid-cycle
        bus.io_cmd_i   = mk_cmd(40'h0);
        bus.io_cmd_v_i = 1'b1;
        tick();
        bus.io_cmd_v_i   = 1'b0;
        bus.tgt_resp_v_i = 2'b10;
        #1;
        chk("arst_pre_v", 128'(bus.io_resp_v_o), 1);
        chk("arst_pre_outstanding", 128'(outstanding), 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_err", 128'(err), 0);
        chk("arst_outstanding", 128'(outstanding), 0);
        chk("arst_resp_v", 128'(bus.io_resp_v_o), 0);
        chk("arst_cmd_ready", 128'(bus.io_cmd_ready_o), 0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        $display("seq error/reset done");

        // Random traffic against the queue model
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [39:0] a;
            logic [1:0]  rv;
            logic [1:0]  rdy;
            logic        v;
            logic        yumi;
            int          s;
            int          pend[2];
            logic [1:0]  exp_cmd_v;
            logic        exp_ready;
            logic        exp_rv;
            logic [1:0]  exp_yumi;

            case ($urandom_range(0, 5))
                0: a = 40'h00_000F_FFFF;
                1: a = 40'h00_0010_0000;
                2: a = 40'h00_001F_FFFF;
                3: a = 40'h00_0020_0000;
                4: a = 40'h00_0010_0000 + 40'($urandom_range(0, 32'hF_FFFF));
                default: a = {8'($urandom), $urandom};
            endcase
            v   = 1'($urandom_range(0, 1));
            rdy = 2'($urandom);
            pend[0] = 0;
            pend[1] = 0;
            foreach (q[k]) pend[q[k]]++;
            for (int t = 0; t < 2; t++) rv[t] = (pend[t] > 0) && ($urandom_range(0, 2) != 0);
            d0 = rnd128();
            d1 = rnd128();

            s         = ref_sel(a);
            exp_cmd_v = (v && q.size() < 4) ? ((s == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_ready = (q.size() < 4) && rdy[s];
            exp_rv    = (q.size() > 0) && rv[q[0]];
            yumi      = exp_rv && ($urandom_range(0, 1) == 1);
            exp_yumi  = yumi ? ((q[0] == 0) ? 2'b01 : 2'b10) : 2'b00;

            cmd = mk_cmd(a);
            bus.io_cmd_i        = cmd;
            bus.io_cmd_v_i      = v;
            bus.tgt_cmd_ready_i = rdy;
            bus.tgt_resp_i      = {d1, d0};
            bus.tgt_resp_v_i    = rv;
            bus.io_resp_yumi_i  = yumi;
            #1;
            chk("rnd_tgt_cmd_v", 128'(bus.tgt_cmd_v_o), 128'(exp_cmd_v));
            chk("rnd_cmd_ready", 128'(bus.io_cmd_ready_o), 128'(exp_ready));
            chk("rnd_resp_v", 128'(bus.io_resp_v_o), 128'(exp_rv));
            chk("rnd_tgt_yumi", 128'(bus.tgt_resp_yumi_o), 128'(exp_yumi));
            if (exp_rv) chk("rnd_resp_data", bus.io_resp_o, (q[0] == 0) ? d0 : d1);
            tick();
            if (yumi) begin
                $display("txn resp tgt=%0d cyc=%0d", q[0], cyc);
                void'(q.pop_front());
            end
            if (v && exp_ready) begin
                q.push_back(s);
                $display("txn cmd addr=%h tgt=%0d cyc=%0d", a, s, cyc);
            end
            chk("rnd_outstanding", 128'(outstanding), 128'(q.size()));
        end
        idle();
        #1;
        chk("rnd_err", 128'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
